// File: rtl/axi4l_master_ipif_if.sv
// AXI4-Lite bus bundle between a single-outstanding master and its target.
interface axi4l_master_ipif_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4l_master_ipif.sv
// Single-outstanding AXI4-Lite master driven by a simple word-addressed
// request/ack user port; writes win over simultaneous reads.
module axi4l_master_ipif #(
  parameter int unsigned C_ADDR_WIDTH = 10,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    up_wr_req,
  input  logic [C_ADDR_WIDTH-3:0] up_wr_addr,
  input  logic [3:0]              up_wr_be,
  input  logic [C_DATA_WIDTH-1:0] up_wr_din,
  output logic                    up_wr_ack,
  output logic [1:0]              up_wr_resp,
  input  logic                    up_rd_req,
  input  logic [C_ADDR_WIDTH-3:0] up_rd_addr,
  output logic                    up_rd_ack,
  output logic [C_DATA_WIDTH-1:0] up_rd_dout,
  output logic [1:0]              up_rd_resp,
  output logic                    busy,
  axi4l_master_ipif_if.master     m_axi
);

  localparam int unsigned AW = C_ADDR_WIDTH - 2;
  localparam int unsigned DW = C_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R} state_t;

  state_t          state_q, state_d;
  logic            aw_valid_q, aw_valid_d;
  logic            w_valid_q, w_valid_d;
  logic            ar_valid_q, ar_valid_d;
  logic            b_ready_q, b_ready_d;
  logic            r_ready_q, r_ready_d;
  logic            wr_ack_q, wr_ack_d;
  logic            rd_ack_q, rd_ack_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   aw_word_q, aw_word_d;
  logic [AW-1:0]   ar_word_q, ar_word_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [1:0]      wr_resp_q, wr_resp_d;
  logic [1:0]      rd_resp_q, rd_resp_d;
  logic [DW-1:0]   rd_dout_q, rd_dout_d;

  // State and every output are registered together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      aw_word_q  <= '0;
      ar_word_q  <= '0;
      strb_q     <= '0;
      wdata_q    <= '0;
      wr_resp_q  <= '0;
      rd_resp_q  <= '0;
      rd_dout_q  <= '0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      busy_q     <= busy_d;
      aw_word_q  <= aw_word_d;
      ar_word_q  <= ar_word_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      wr_resp_q  <= wr_resp_d;
      rd_resp_q  <= rd_resp_d;
      rd_dout_q  <= rd_dout_d;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = 1'b0;
    r_ready_d  = 1'b0;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    aw_word_d  = aw_word_q;
    ar_word_d  = ar_word_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    wr_resp_d  = wr_resp_q;
    rd_resp_d  = rd_resp_q;
    rd_dout_d  = rd_dout_q;

    case (state_q)
      IDLE: begin
        if (up_wr_req) begin
          aw_word_d  = up_wr_addr;
          strb_d     = up_wr_be;
          wdata_d    = up_wr_din;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = WR;
        end else if (up_rd_req) begin
          ar_word_d  = up_rd_addr;
          ar_valid_d = 1'b1;
          state_d    = RD_AR;
        end
      end
      WR: begin
        // AW and W retire independently; B opens once both are done.
        aw_valid_d = aw_valid_q && !m_axi.awready;
        w_valid_d  = w_valid_q && !m_axi.wready;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = WR_B;
          b_ready_d = 1'b1;
        end
      end
      WR_B: begin
        if (m_axi.bvalid) begin
          state_d   = IDLE;
          wr_ack_d  = 1'b1;
          wr_resp_d = m_axi.bresp;
        end else begin
          b_ready_d = 1'b1;
        end
      end
      RD_AR: begin
        if (m_axi.arready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RD_R;
        end
      end
      RD_R: begin
        if (m_axi.rvalid) begin
          state_d   = IDLE;
          rd_ack_d  = 1'b1;
          rd_dout_d = m_axi.rdata;
          rd_resp_d = m_axi.rresp;
        end else begin
          r_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign m_axi.awaddr  = 32'({aw_word_q, 2'b00});
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = aw_valid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = strb_q;
  assign m_axi.wvalid  = w_valid_q;
  assign m_axi.bready  = b_ready_q;
  assign m_axi.araddr  = 32'({ar_word_q, 2'b00});
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = ar_valid_q;
  assign m_axi.rready  = r_ready_q;

  assign up_wr_ack  = wr_ack_q;
  assign up_wr_resp = wr_resp_q;
  assign up_rd_ack  = rd_ack_q;
  assign up_rd_dout = rd_dout_q;
  assign up_rd_resp = rd_resp_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_axi4l_master_ipif.sv
// Bench for axi4l_master_ipif: transaction-level model of the user port and
// AXI phases, a configurable/random slave, and a per-cycle compare.
module tb_axi4l_master_ipif;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          up_wr_req, up_rd_req, up_wr_ack, up_rd_ack, busy;
  logic [AW-1:0] up_wr_addr, up_rd_addr;
  logic [3:0]    up_wr_be;
  logic [31:0]   up_wr_din, up_rd_dout;
  logic [1:0]    up_wr_resp, up_rd_resp;

  axi4l_master_ipif_if bus ();

  axi4l_master_ipif #(.C_ADDR_WIDTH(10), .C_DATA_WIDTH(32)) dut (
    .aclk(clk), .aresetn(rst_n),
    .up_wr_req(up_wr_req), .up_wr_addr(up_wr_addr), .up_wr_be(up_wr_be),
    .up_wr_din(up_wr_din), .up_wr_ack(up_wr_ack), .up_wr_resp(up_wr_resp),
    .up_rd_req(up_rd_req), .up_rd_addr(up_rd_addr), .up_rd_ack(up_rd_ack),
    .up_rd_dout(up_rd_dout), .up_rd_resp(up_rd_resp), .busy(busy),
    .m_axi(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Requests and slave configuration, written only by the main sequence.
  bit            do_wr = 0, do_rd = 0, rand_mode = 0;
  logic [AW-1:0] s_wr_addr = '0, s_rd_addr = '0;
  logic [3:0]    s_wr_be = '0;
  logic [31:0]   s_wr_din = '0, cfg_rdata = '0;
  logic [1:0]    cfg_bresp = '0, cfg_rresp = '0;
  int            aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;

  // Slave state and observations, written only by the cycle process.
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int rnd_aw, rnd_w, rnd_ar, rnd_b, rnd_r;
  int n_aw_hs = 0, n_ar_cyc = 0, n_wr_ack = 0, n_rd_ack = 0;
  int aw_hs_cyc, w_hs_cyc, ar_hs_cyc, wr_ack_cyc, rd_ack_cyc, wr_acc_cyc, rd_acc_cyc;
  logic [31:0] aw_hs_addr, w_hs_data;

  // Model: expected value of every DUT output in the current cycle.
  bit          e_busy, e_is_wr, e_aw, e_w, e_ar, e_bready, e_rready, e_wr_ack, e_rd_ack;
  logic [31:0] e_awaddr, e_wdata, e_araddr, e_rd_dout;
  logic [3:0]  e_wstrb;
  logic [1:0]  e_wr_resp, e_rd_resp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    {e_busy, e_is_wr, e_aw, e_w, e_ar, e_bready, e_rready, e_wr_ack, e_rd_ack} = '0;
    e_awaddr = '0; e_wdata = '0; e_araddr = '0; e_rd_dout = '0;
    e_wstrb = '0; e_wr_resp = '0; e_rd_resp = '0;
    {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
    {rnd_aw, rnd_w, rnd_ar, rnd_b, rnd_r} = '0;
  endtask

  task automatic check_outputs(input bit in_rst);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("awvalid", 32'(bus.awvalid), 32'(e_aw));
    chk("wvalid", 32'(bus.wvalid), 32'(e_w));
    chk("arvalid", 32'(bus.arvalid), 32'(e_ar));
    chk("bready", 32'(bus.bready), 32'(e_bready));
    chk("rready", 32'(bus.rready), 32'(e_rready));
    chk("wr_ack", 32'(up_wr_ack), 32'(e_wr_ack));
    chk("rd_ack", 32'(up_rd_ack), 32'(e_rd_ack));
    chk("wr_resp", 32'(up_wr_resp), 32'(e_wr_resp));
    chk("rd_resp", 32'(up_rd_resp), 32'(e_rd_resp));
    chk("rd_dout", up_rd_dout, e_rd_dout);
    chk("awprot", 32'(bus.awprot), 32'(0));
    chk("arprot", 32'(bus.arprot), 32'(0));
    if (e_aw || in_rst) chk("awaddr", bus.awaddr, e_awaddr);
    if (e_w || in_rst) begin
      chk("wdata", bus.wdata, e_wdata);
      chk("wstrb", 32'(bus.wstrb), 32'(e_wstrb));
    end
    if (e_ar || in_rst) chk("araddr", bus.araddr, e_araddr);
  endtask

  function automatic int pick(input int fixed, input int rnd);
    return rand_mode ? rnd : fixed;
  endfunction

  // Per cycle: compare, drive slave and requests, then advance the model.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_reset();
      check_outputs(1'b1);
      {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} = '0;
      bus.bresp = '0; bus.rresp = '0; bus.rdata = '0;
      up_wr_req = 1'b0; up_rd_req = 1'b0;
      up_wr_addr = '0; up_rd_addr = '0; up_wr_be = '0; up_wr_din = '0;
    end else begin
      check_outputs(1'b0);
      if (up_wr_ack === 1'b1) begin n_wr_ack++; wr_ack_cyc = cyc; end
      if (up_rd_ack === 1'b1) begin n_rd_ack++; rd_ack_cyc = cyc; end

      bus.awready = bus.awvalid && (aw_wait >= pick(aw_dly, rnd_aw));
      bus.wready  = bus.wvalid && (w_wait >= pick(w_dly, rnd_w));
      bus.arready = bus.arvalid && (ar_wait >= pick(ar_dly, rnd_ar));
      bus.bvalid  = bus.bready && (b_wait >= pick(b_dly, rnd_b));
      bus.rvalid  = bus.rready && (r_wait >= pick(r_dly, rnd_r));
      bus.bresp   = rand_mode ? 2'($urandom_range(0, 3)) : cfg_bresp;
      bus.rresp   = rand_mode ? 2'($urandom_range(0, 3)) : cfg_rresp;
      bus.rdata   = rand_mode ? $urandom : cfg_rdata;

      up_wr_req = do_wr; up_wr_addr = s_wr_addr; up_wr_be = s_wr_be; up_wr_din = s_wr_din;
      up_rd_req = do_rd; up_rd_addr = s_rd_addr;

      if (bus.awvalid && bus.awready) begin
        n_aw_hs++; aw_hs_cyc = cyc; aw_hs_addr = bus.awaddr;
        rnd_aw = $urandom_range(0, 3);
      end
      if (bus.wvalid && bus.wready) begin
        w_hs_cyc = cyc; w_hs_data = bus.wdata; rnd_w = $urandom_range(0, 3);
      end
      if (bus.arvalid) n_ar_cyc++;
      if (bus.arvalid && bus.arready) begin ar_hs_cyc = cyc; rnd_ar = $urandom_range(0, 3); end
      if (bus.bready && bus.bvalid) rnd_b = $urandom_range(0, 3);
      if (bus.rready && bus.rvalid) rnd_r = $urandom_range(0, 4);
      aw_wait = (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  = (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
      ar_wait = (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;
      b_wait  = (bus.bready && !bus.bvalid) ? b_wait + 1 : 0;
      r_wait  = (bus.rready && !bus.rvalid) ? r_wait + 1 : 0;

      // One transaction at a time; requests while one is open are dropped.
      e_wr_ack = 1'b0;
      e_rd_ack = 1'b0;
      if (!e_busy) begin
        if (up_wr_req) begin
          e_busy = 1; e_is_wr = 1; e_aw = 1; e_w = 1;
          e_awaddr = 32'({up_wr_addr, 2'b00}); e_wdata = up_wr_din; e_wstrb = up_wr_be;
          wr_acc_cyc = cyc;
        end else if (up_rd_req) begin
          e_busy = 1; e_is_wr = 0; e_ar = 1;
          e_araddr = 32'({up_rd_addr, 2'b00});
          rd_acc_cyc = cyc;
        end
      end else if (e_is_wr) begin
        if (e_bready) begin
          if (bus.bvalid) begin e_busy = 0; e_bready = 0; e_wr_ack = 1; e_wr_resp = bus.bresp; end
        end else begin
          e_aw = e_aw && !bus.awready;
          e_w  = e_w && !bus.wready;
          if (!e_aw && !e_w) e_bready = 1;
        end
      end else begin
        if (e_rready) begin
          if (bus.rvalid) begin
            e_busy = 0; e_rready = 0; e_rd_ack = 1;
            e_rd_dout = bus.rdata; e_rd_resp = bus.rresp;
          end
        end else if (bus.arready) begin
          e_ar = 0; e_rready = 1;
        end
      end
    end
  end

  task automatic issue(input bit wr, input bit rd, input logic [AW-1:0] wa,
                       input logic [3:0] be, input logic [31:0] din, input logic [AW-1:0] ra);
    @(posedge clk); #1;
    do_wr = wr; do_rd = rd; s_wr_addr = wa; s_wr_be = be; s_wr_din = din; s_rd_addr = ra;
    @(posedge clk); #1;
    do_wr = 0; do_rd = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (e_busy && t < 200) begin @(posedge clk); #1; t++; end
    @(negedge clk); #1;
    chk("wait_done", 32'(busy), 32'(0));
  endtask

  initial begin
    int n0, n1, t;
    bit [1:0] op;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait write: 0x05 -> byte address 0x14, ack three cycles later.
    issue(1, 0, 8'h05, 4'hF, 32'hDEADBEEF, '0);
    wait_done();
    chk("w0_awaddr", aw_hs_addr, 32'h14);
    chk("w0_wdata", w_hs_data, 32'hDEADBEEF);
    chk("w0_aw_lat", 32'(aw_hs_cyc - wr_acc_cyc), 32'd1);
    chk("w0_ack_lat", 32'(wr_ack_cyc - wr_acc_cyc), 32'd3);
    chk("w0_resp", 32'(up_wr_resp), 32'd0);

    // AW accepted four cycles late, W at once: one ack only.
    aw_dly = 4; cfg_bresp = 2'b01; n0 = n_wr_ack;
    issue(1, 0, 8'h3A, 4'h5, 32'hCAFEF00D, '0);
    wait_done();
    repeat (3) @(posedge clk);
    chk("skew_aw_lat", 32'(aw_hs_cyc - wr_acc_cyc), 32'd5);
    chk("skew_w_lat", 32'(w_hs_cyc - wr_acc_cyc), 32'd1);
    chk("skew_awaddr", aw_hs_addr, 32'hE8);
    chk("skew_acks", 32'(n_wr_ack - n0), 32'd1);
    chk("skew_resp", 32'(up_wr_resp), 32'd1);
    aw_dly = 0;

    // Read with rvalid five cycles late and SLVERR passed through.
    r_dly = 5; cfg_rdata = 32'h12345678; cfg_rresp = 2'b10; n0 = n_rd_ack;
    issue(0, 1, '0, '0, '0, 8'h10);
    wait_done();
    chk("rd_dout", up_rd_dout, 32'h12345678);
    chk("rd_resp_lit", 32'(up_rd_resp), 32'd2);
    chk("rd_lat", 32'(rd_ack_cyc - rd_acc_cyc), 32'd8);
    chk("rd_acks", 32'(n_rd_ack - n0), 32'd1);
    r_dly = 0;

    // Simultaneous requests: write wins; a read while busy is dropped.
    b_dly = 2; n0 = n_ar_cyc; n1 = n_aw_hs;
    issue(1, 1, 8'h21, 4'h3, 32'h0BADBEEF, 8'h22);
    issue(0, 1, '0, '0, '0, 8'h23);
    wait_done();
    repeat (2) @(posedge clk);
    chk("both_no_ar", 32'(n_ar_cyc - n0), 32'd0);
    chk("both_one_aw", 32'(n_aw_hs - n1), 32'd1);
    b_dly = 0;

    // Read requested in the write-ack cycle starts AR the next cycle.
    issue(1, 0, 8'h40, 4'hF, 32'h11112222, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_rd = 1; s_rd_addr = 8'h41;
    @(posedge clk); #1;
    do_rd = 0;
    wait_done();
    chk("b2b_rd_in_ack", 32'(rd_acc_cyc), 32'(wr_ack_cyc));
    chk("b2b_ar_next", 32'(ar_hs_cyc - rd_acc_cyc), 32'd1);

    // Reset while waiting on B: no ack, next write behaves normally.
    b_dly = 6;
    issue(1, 0, 8'h55, 4'hA, 32'h55AA55AA, '0);
    t = 0;
    while (bus.bready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    chk("rst_reach_wr_b", 32'(bus.bready), 32'd1);
    n0 = n_wr_ack;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    b_dly = 0;
    repeat (5) @(posedge clk);
    chk("rst_no_ack", 32'(n_wr_ack - n0), 32'd0);
    issue(1, 0, 8'h07, 4'hC, 32'h0F0F0F0F, '0);
    wait_done();
    chk("rst_next_lat", 32'(wr_ack_cyc - wr_acc_cyc), 32'd3);
    chk("rst_next_addr", aw_hs_addr, 32'h1C);

    // Random traffic, random slave timing and responses.
    rand_mode = 1;
    for (int i = 0; i < 250; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(op[0], op[1], AW'($urandom), 4'($urandom), $urandom, AW'($urandom));
      if ($urandom_range(0, 2) == 0) wait_done();
      else repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_done();
    rand_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
